// File: rtl/regfile_dump_reader_if.sv
// Byte stream from the register dump engine to the UART transmitter.
// Valid/ready handshake; a byte moves on a clock edge with both high.
interface regfile_dump_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: walks the register file read port and streams a
// sync byte followed by every register, little-endian, over tx.
module regfile_dump_reader #(
  parameter int          NUM_REGS  = 32,
  parameter int          ADDR_W    = 5,
  parameter int          DATA_W    = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  regfile_dump_reader_if.master tx,
  output logic                  busy,
  output logic                  done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_nx;
  logic                xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shift_d    = shift_q;
    idx_d      = idx_q;
    shift_nx   = shift_q >> 8;
    xfer       = tx_valid_q && tx.tx_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          busy_d     = 1'b1;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
        end
      end
      S_HDR: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          rd_addr_d  = '0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        shift_d    = rd_data;
        idx_d      = '0;
        tx_data_d  = rd_data[7:0];
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (idx_q != LAST_IDX) begin
            shift_d   = shift_nx;
            tx_data_d = shift_nx[7:0];
            idx_d     = idx_q + 1'b1;
          end else begin
            tx_valid_d = 1'b0;
            if (rd_addr_q == LAST_ADDR) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              rd_addr_d = rd_addr_q + 1'b1;
              state_d   = S_READ;
            end
          end
        end
      end
      S_DONE: begin
        // busy drops together with the done pulse
        busy_d    = 1'b0;
        rd_addr_d = '0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_addr     = rd_addr_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: random backpressure and register
// contents against a byte-stream model built from the register image.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NBYTES   = 1 + NUM_REGS * DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rf  [NUM_REGS];
  logic [DATA_W-1:0] img [NUM_REGS];

  regfile_dump_reader_if txi();

  regfile_dump_reader #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx      (txi),
    .busy    (busy),
    .done    (done)
  );

  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] got [$];
  logic [7:0] exp [$];
  int n_done;
  int done_cyc;
  int stall_viol;
  int busy_bad;

  task automatic load_rf();
    for (int i = 0; i < NUM_REGS; i++) rf[i] = img[i];
  endtask

  task automatic build_exp();
    exp.delete();
    exp.push_back(8'hA5);
    for (int r = 0; r < NUM_REGS; r++)
      for (int b = 0; b < DATA_W / 8; b++)
        exp.push_back(img[r][8*b +: 8]);
  endtask

  task automatic pattern_img();
    for (int i = 0; i < NUM_REGS; i++) img[i] = 32'h0101_0000 + i;
    img[0] = '0;
  endtask

  task automatic random_img();
    for (int i = 0; i < NUM_REGS; i++) img[i] = $urandom;
  endtask

  function automatic int first_diff();
    int n;
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      if (got[i] !== exp[i]) return i;
    if (got.size() != exp.size()) return n;
    return -1;
  endfunction

  // Runs the bench side of a dump; entered and left on a negedge.
  task automatic collect(input int bp_pct, input bit extra,
                         input bit do_start, input bit stop_at_done,
                         input int abort_at, input bit wr_test,
                         input int limit);
    bit         pstall = 1'b0;
    logic [7:0] pd = '0;
    bit         f5 = 1'b0, f60 = 1'b0, f128 = 1'b0;
    bit         w1 = 1'b0, w2 = 1'b0;
    bit         rdy;
    int         cyc;
    got.delete();
    n_done = 0;
    done_cyc = -1;
    stall_viol = 0;
    busy_bad = 0;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 1;
    while (cyc <= limit) begin
      if (done_cyc >= 0 && cyc > done_cyc + 4) break;
      if (pstall && (txi.tx_valid !== 1'b1 || txi.tx_data !== pd))
        stall_viol++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy !== 1'b1) busy_bad++;
      end else if (n_done == 0) begin
        if (busy !== 1'b1) busy_bad++;
      end else if (busy !== 1'b0) begin
        busy_bad++;
      end
      if (stop_at_done && done === 1'b1) return;
      if (abort_at >= 0 && got.size() == abort_at &&
          txi.tx_valid === 1'b1) return;
      if (wr_test && !w1 && got.size() == 1) begin
        rf[5] = 32'hDEAD_BEEF;
        w1 = 1'b1;
      end
      if (wr_test && !w2 && got.size() == 21 && txi.tx_valid === 1'b1) begin
        rf[5] = '0;
        w2 = 1'b1;
      end
      rdy = ($urandom_range(0, 99) >= bp_pct);
      txi.tx_ready = rdy;
      start = 1'b0;
      if (extra) begin
        if (!f5 && got.size() == 5) begin start = 1'b1; f5 = 1'b1; end
        if (!f60 && got.size() == 60) begin start = 1'b1; f60 = 1'b1; end
        if (!f128 && got.size() == 128) begin start = 1'b1; f128 = 1'b1; end
        if (done === 1'b1) start = 1'b1;
      end
      if (txi.tx_valid === 1'b1 && rdy) got.push_back(txi.tx_data);
      pstall = (txi.tx_valid === 1'b1) && !rdy;
      pd = txi.tx_data;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    txi.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    pattern_img();
    load_rf();
    rst_n = 1'b0;
    start = 1'b0;
    txi.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txi.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_valid: got %b want 0", txi.tx_valid);
    end
    checks++;
    if (txi.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx_data: got %h want 00", txi.tx_data);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
    end
    checks++;
    if (rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_rd_addr: got %0d want 0", rd_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle();
    int bad = 0;
    start = 1'b0;
    txi.tx_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (txi.tx_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || rd_addr !== '0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_full_dump();
    int d;
    pattern_img();
    load_rf();
    build_exp();
    collect(0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 400);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL full_stream: diff at byte %0d, got %0d bytes want %0d",
               d, got.size(), exp.size());
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL full_done_count: got %0d want 1", n_done);
    end
    checks++;
    if (done_cyc != 162) begin
      errors++;
      $display("FAIL full_latency: done at cycle %0d want 162", done_cyc);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL full_busy: %0d bad busy cycles want 0", busy_bad);
    end
    checks++;
    if (rd_addr !== '0 || txi.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_end_state: rd_addr=%0d tx_valid=%b want 0/0",
               rd_addr, txi.tx_valid);
    end
  endtask

  task automatic test_backpressure(input int pct);
    int d;
    random_img();
    load_rf();
    build_exp();
    collect(pct, 1'b0, 1'b1, 1'b0, -1, 1'b0, 3000);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL bp%0d_stream: diff at byte %0d, got %0d bytes want %0d",
               pct, d, got.size(), exp.size());
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL bp%0d_hold: %0d unstable stalls want 0", pct, stall_viol);
    end
    checks++;
    if (n_done != 1 || busy_bad != 0) begin
      errors++;
      $display("FAIL bp%0d_done: done=%0d busy_bad=%0d want 1/0",
               pct, n_done, busy_bad);
    end
  endtask

  task automatic test_start_ignored();
    int d;
    pattern_img();
    load_rf();
    build_exp();
    collect(10, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1000);
    d = first_diff();
    checks++;
    if (got.size() != NBYTES || d != -1) begin
      errors++;
      $display("FAIL restart_ignored: got %0d bytes diff at %0d want %0d",
               got.size(), d, NBYTES);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    pattern_img();
    load_rf();
    build_exp();
    collect(0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 400);
    checks++;
    if (done_cyc != 162) begin
      errors++;
      $display("FAIL b2b_first_done: done at %0d want 162", done_cyc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b want 0/0", busy, done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (txi.tx_valid !== 1'b1 || txi.tx_data !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_header: valid=%b data=%h busy=%b want 1/a5/1",
               txi.tx_valid, txi.tx_data, busy);
    end
    collect(0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 400);
    d = first_diff();
    checks++;
    if (d != -1 || done_cyc != 162) begin
      errors++;
      $display("FAIL b2b_second: diff at %0d, done at %0d want -1/162",
               d, done_cyc);
    end
  endtask

  task automatic test_reset_mid_send();
    int d;
    int bad = 0;
    pattern_img();
    load_rf();
    build_exp();
    collect(20, 1'b0, 1'b1, 1'b0, 43, 1'b0, 1000);
    checks++;
    if (got.size() != 43 || rd_addr !== 5'd10) begin
      errors++;
      $display("FAIL abort_point: bytes=%0d rd_addr=%0d want 43/10",
               got.size(), rd_addr);
    end
    txi.tx_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txi.tx_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL abort_immediate: valid=%b busy=%b rd_addr=%0d want 0/0/0",
               txi.tx_valid, busy, rd_addr);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || txi.tx_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles want 0", bad);
    end
    collect(0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 400);
    d = first_diff();
    checks++;
    if (d != -1 || n_done != 1) begin
      errors++;
      $display("FAIL abort_redump: diff at %0d done=%0d want -1/1", d, n_done);
    end
  endtask

  task automatic test_concurrent_write();
    int d;
    pattern_img();
    load_rf();
    img[5] = 32'hDEAD_BEEF;
    build_exp();
    collect(0, 1'b0, 1'b1, 1'b0, -1, 1'b1, 400);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL rf_write_stream: diff at byte %0d, got %0d bytes want %0d",
               d, got.size(), exp.size());
    end
    checks++;
    if (got.size() < 25 || {got[24], got[23], got[22], got[21]} !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rf_write_reg5: got %0d bytes, reg5 mismatch want deadbeef",
               got.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_dump();
    test_backpressure(30);
    test_backpressure(60);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_send();
    test_concurrent_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug read-out engine for the 32x32 register file.
- On a start pulse it walks every register address on a spare read port (A-port) and captures each 32-bit word.
- Each word is serialized into bytes on a valid/ready byte stream, ahead of the UART transmitter, so the host can dump full CPU register state.
- Read-only towards the register file; it never drives write enable.

Parameters:
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1)
- ADDR_W, 5, register address width
- DATA_W, 32, register width; must be a multiple of 8
- SYNC_BYTE, 8'hA5, header byte sent before the first register

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a dump
- rd_addr  output  ADDR_W  register file read address
- rd_data  input  DATA_W  register file read data; combinational function of rd_addr
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts byte this cycle
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_addr=0, tx_data=0, tx_valid=0, busy=0, done=0; shift register and byte counter cleared.
- Reset asserted mid-dump aborts immediately. No further bytes are sent and done is not pulsed.
- All outputs are registered.
- Byte handshake:
  - A byte transfers on a clk edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer.
- IDLE: busy=0. When start=1: go to HDR, set busy=1, tx_data=SYNC_BYTE, tx_valid=1.
- start while busy=1 is ignored (no restart, no queuing).
- HDR: on transfer, set tx_valid=0, rd_addr=0, go to READ.
- READ (one cycle): capture rd_data into the 32-bit shift register, set byte index=0, go to SEND.
  - In the SEND entry cycle, tx_data = captured[7:0] and tx_valid=1.
- SEND: bytes are little-endian, LSB byte first.
  - On each transfer with byte index < DATA_W/8-1: shift right by 8, present the next byte, increment the index. tx_valid stays 1, so back-to-back transfers are possible every cycle.
  - On transfer of the last byte with rd_addr < NUM_REGS-1: tx_valid=0, rd_addr increments, go to READ.
  - On transfer of the last byte with rd_addr = NUM_REGS-1: tx_valid=0, go to DONE.
- DONE (one cycle): done=1, busy=0 next, rd_addr returns to 0, go to IDLE.
  - A start in the DONE cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- Byte count per dump: 1 + NUM_REGS*DATA_W/8 = 129 with defaults.
- Minimum duration (tx_ready held 1): 1 HDR + 32*(1 READ + 4 SEND) + 1 DONE = 162 cycles from the start edge to the done pulse.
- rd_addr is stable for the whole READ cycle. The register file may be written concurrently; the value captured is whatever rd_data shows at the READ edge, including a write landing that same edge per register-file semantics.
- Register 0 is dumped as read (expected 0); no special-casing.
- rd_addr does not wrap past NUM_REGS-1.

Test Plan:
- Reset, then preload RF[i]=32'h0101_0000+i and RF[0]=0; pulse start with tx_ready=1 -> 129 bytes are accepted. Expected stream:
  - A5 first.
  - Then 00 00 00 00 for RF[0], 01 00 01 01 for RF[1], ..., 1F 00 01 01 for RF[31].
  - done pulses exactly once, 162 cycles after start; busy falls with done.
- Backpressure: tx_ready toggles pseudo-randomly (~30% low) -> identical byte stream. tx_data/tx_valid never change while tx_valid=1 and tx_ready=0; no byte is dropped or duplicated.
- start pulses repeated during the dump (at bytes 5, 60, 128) -> ignored: exactly 129 bytes, single done. A start one cycle after done begins a new A5 header.
- rst_n driven low for 1 cycle mid-SEND (register 10, byte 2), asynchronously between edges -> tx_valid=0, busy=0, rd_addr=0 immediately; no done. A new start then gives a full 129-byte dump.
- Write RF[5]=32'hDEADBEEF during the dump before register 5 is read, then write RF[5]=32'h0 after its READ cycle -> stream carries EF BE AD DE for register 5.
- Idle check: start held 0 for 100 cycles after reset -> tx_valid=0, busy=0, done=0, rd_addr=0 throughout.
